// File: rtl/timer_arbiter.sv
// Round-robin arbiter that shares one countdown timer between NREQ requesters.
// Define TIMER_ARB_FIXED_PRIORITY_EN to select the lowest requesting index instead of round-robin.
module timer_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    cycles,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [$clog2(NREQ)-1:0]  active_id,
  output logic                     ctl_busy,
  output logic                     timer_load,
  output logic [WIDTH-1:0]         timer_cycles,
  input  logic                     timer_busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [IDW-1:0]     active_q, active_d;
  logic [IDW-1:0]     last_q, last_d;
  logic               timer_load_q, timer_load_d;
  logic [WIDTH-1:0]   timer_cycles_q, timer_cycles_d;

  logic               sel_found;
  logic [IDW-1:0]     sel_id;
  logic [WIDTH-1:0]   sel_cycles;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
`ifdef TIMER_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_found && req[i]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(i);
      end
    end
`else
    // Scan upward from the requester after the last one serviced.
    for (int i = 1; i <= NREQ; i++) begin
      if (!sel_found && req[(int'(last_q) + i) % NREQ]) begin
        sel_found = 1'b1;
        sel_id    = IDW'((int'(last_q) + i) % NREQ);
      end
    end
`endif
    sel_cycles = cycles[int'(sel_id)*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    done_d         = '0;
    active_d       = active_q;
    last_d         = last_q;
    timer_load_d   = 1'b0;
    timer_cycles_d = timer_cycles_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d        = S_LOAD;
          active_d       = sel_id;
          timer_cycles_d = sel_cycles;
          grant_d        = NREQ'(1) << sel_id;
          timer_load_d   = (sel_cycles != '0);
        end
      end
      S_LOAD: begin
        // A zero count never raises timer busy, so skip the wait entirely.
        if (timer_cycles_q == '0) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!timer_busy) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        last_d  = active_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      done_q         <= '0;
      active_q       <= '0;
      last_q         <= IDW'(NREQ - 1);
      timer_load_q   <= 1'b0;
      timer_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      done_q         <= done_d;
      active_q       <= active_d;
      last_q         <= last_d;
      timer_load_q   <= timer_load_d;
      timer_cycles_q <= timer_cycles_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign active_id    = active_q;
  assign ctl_busy     = (state_q != S_IDLE);
  assign timer_load   = timer_load_q;
  assign timer_cycles = timer_cycles_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a behavioural countdown timer attached.
// Cycle 0 of each scenario is the first IDLE cycle after reset is released.
module tb_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 80;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   cycles;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic [1:0]              active_id;
  logic                    ctl_busy;
  logic                    timer_load;
  logic [WIDTH-1:0]        timer_cycles;
  logic                    timer_busy;

  logic [WIDTH-1:0]        cnt;

  int n_chk = 0;
  int n_err = 0;
  logic auto_drop;

  logic [NREQ-1:0]  g_t  [DEPTH];
  logic [NREQ-1:0]  d_t  [DEPTH];
  logic             tl_t [DEPTH];
  logic [WIDTH-1:0] tc_t [DEPTH];
  logic             bz_t [DEPTH];
  logic             tb_t [DEPTH];
  logic [1:0]       id_t [DEPTH];

  timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .cycles       (cycles),
    .grant        (grant),
    .done         (done),
    .active_id    (active_id),
    .ctl_busy     (ctl_busy),
    .timer_load   (timer_load),
    .timer_cycles (timer_cycles),
    .timer_busy   (timer_busy)
  );

  always #5 clk = ~clk;

  // Shared countdown timer: busy is combinational counter > 0.
  always_ff @(posedge clk) begin
    if (reset)           cnt <= '0;
    else if (timer_load) cnt <= timer_cycles;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end
  assign timer_busy = (cnt != '0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    cycles = '0;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  // Records outputs for n cycles starting at the current cycle (index 0).
  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      g_t[c]  = grant;
      d_t[c]  = done;
      tl_t[c] = timer_load;
      tc_t[c] = timer_cycles;
      bz_t[c] = ctl_busy;
      tb_t[c] = timer_busy;
      id_t[c] = active_id;
      if (auto_drop) req = req & ~done;
      tick();
    end
  endtask

  task automatic onehot_and_pulses(input string tag, input int n, input int exp_loads, input int exp_dones);
    int bad = 0;
    int loads = 0;
    int dones = 0;
    for (int c = 0; c < n; c++) begin
      if ((g_t[c] & (g_t[c] - 1'b1)) != '0) bad++;
      if (tl_t[c]) loads++;
      if (d_t[c] != '0) dones++;
    end
    check({tag, "_multihot"}, bad, 0);
    check({tag, "_loads"}, loads, exp_loads);
    check({tag, "_dones"}, dones, exp_dones);
  endtask

  initial begin
    logic [NREQ-1:0] seq[$];
    int hits3;

    auto_drop = 1'b1;
    reset     = 1'b1;
    req       = '0;
    cycles    = '0;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_tload", timer_load, 0);
    check("rst_tcycles", timer_cycles, 0);
    check("rst_active", active_id, 0);
    check("rst_busy", ctl_busy, 0);
    reset = 1'b0;

    // Single request, count 5
    req = 4'b0010;
    cycles[1*WIDTH +: WIDTH] = 16'd5;
    capture(12);
    check("s1_grant1", g_t[1], 4'b0010);
    check("s1_tload1", tl_t[1], 1);
    check("s1_tcyc1", tc_t[1], 5);
    check("s1_id1", id_t[1], 1);
    check("s1_tload2", tl_t[2], 0);
    check("s1_tbusy6", tb_t[6], 1);
    check("s1_tbusy7", tb_t[7], 0);
    check("s1_done7", d_t[7], 0);
    check("s1_done8", d_t[8], 4'b0010);
    check("s1_grant8", g_t[8], 4'b0010);
    check("s1_busy9", bz_t[9], 0);
    onehot_and_pulses("s1", 12, 1, 1);

    // All four at once, count 2
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) cycles[i*WIDTH +: WIDTH] = 16'd2;
    capture(26);
    check("s2_grant1", g_t[1], 4'b0001);
    check("s2_grant7", g_t[7], 4'b0010);
    check("s2_grant13", g_t[13], 4'b0100);
    check("s2_grant19", g_t[19], 4'b1000);
    check("s2_done5", d_t[5], 4'b0001);
    check("s2_done11", d_t[11], 4'b0010);
    check("s2_done17", d_t[17], 4'b0100);
    check("s2_done23", d_t[23], 4'b1000);
    check("s2_idle24", bz_t[24], 0);
    onehot_and_pulses("s2", 26, 4, 4);

    // Zero count bypasses the timer
    do_reset();
    req = 4'b0100;
    capture(6);
    check("s3_grant1", g_t[1], 4'b0100);
    check("s3_done2", d_t[2], 4'b0100);
    check("s3_busy3", bz_t[3], 0);
    onehot_and_pulses("s3", 6, 0, 1);

    // Reset during WAIT
    do_reset();
    req = 4'b0001;
    cycles[0*WIDTH +: WIDTH] = 16'd100;
    capture(10);
    check("s4_wait_busy9", bz_t[9], 1);
    check("s4_tbusy9", tb_t[9], 1);
    reset = 1'b1;
    tick();
    check("s4_grant11", grant, 0);
    check("s4_busy11", ctl_busy, 0);
    check("s4_tbusy11", timer_busy, 0);
    check("s4_done11", done, 0);
    reset = 1'b0;
    req   = 4'b1000;
    cycles[3*WIDTH +: WIDTH] = 16'd1;
    capture(8);
    check("s4_newgrant", g_t[1], 4'b1000);
    check("s4_newdone", d_t[4], 4'b1000);
    onehot_and_pulses("s4", 8, 1, 1);

    // Fairness: requesters 0 and 3 held high
    do_reset();
    auto_drop = 1'b0;
    req = 4'b1001;
    cycles[0*WIDTH +: WIDTH] = 16'd3;
    cycles[3*WIDTH +: WIDTH] = 16'd3;
    capture(72);
    req = '0;
    for (int c = 0; c < 72; c++)
      if (g_t[c] != '0 && (c == 0 || g_t[c-1] == '0)) seq.push_back(g_t[c]);
    check("s5_services", seq.size() >= 10, 1);
    hits3 = 0;
    for (int k = 0; k < seq.size(); k++) if (seq[k] == 4'b1000) hits3++;
`ifdef TIMER_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < 4; k++)
      check($sformatf("s5_seq%0d", k), (k < seq.size()) ? seq[k] : 4'hx, 4'b0001);
    check("s5_starved3", hits3, 0);
`else
    for (int k = 0; k < 4; k++)
      check($sformatf("s5_seq%0d", k), (k < seq.size()) ? seq[k] : 4'hx,
            (k % 2 == 0) ? 4'b0001 : 4'b1000);
    check("s5_hits3", hits3, seq.size() / 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin controller that shares one `timer` countdown instance between NREQ requesters. Each requester raises a request with its own cycle count. The arbiter grants one requester at a time, loads the shared timer, waits for it to expire, and then returns a one-cycle completion pulse to that requester. It sits between the requesting blocks and the single `timer` instance, driving that instance's `load`/`cycles` inputs and observing its `busy` output.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 16: cycle-count width; matches the timer's `cycles` port.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset. Also tied to the timer's reset at top level.
- req  in  NREQ  per-requester request level. Held high until the matching `done` pulse.
- cycles  in  NREQ*WIDTH  packed cycle counts. Requester i uses bits [i*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot; active requester from the LOAD state through the DONE state.
- done  out  NREQ  one-cycle pulse to the serviced requester.
- active_id  out  $clog2(NREQ)  index of the current or last granted requester.
- ctl_busy  out  1  high in any state other than IDLE.
- timer_load  out  1  drives the timer's `load` input.
- timer_cycles  out  WIDTH  drives the timer's `cycles` input.
- timer_busy  in  1  from the timer's `busy` output; combinational `counter > 0`.

## Operation

The FSM has four states: IDLE, LOAD, WAIT and DONE. Every output is registered or is a decode of registered state.

- **IDLE:**
  - If `req != 0`, select the first asserted requester scanning upward from `last+1` modulo NREQ.
  - Latch the selected index into `active_id` and its count into `timer_cycles`, then go to LOAD.
  - `timer_busy` is ignored in IDLE.
- **LOAD:**
  - `grant[active_id]=1`.
  - `timer_load = (timer_cycles != 0)`.
  - If `timer_cycles == 0`, go to DONE: the timer is bypassed because it never asserts `busy` for 0.
  - Otherwise go to WAIT.
- **WAIT:** hold the grant. When `timer_busy == 0`, go to DONE.
- **DONE:**
  - `done[active_id]=1` and grant is still held.
  - Set `last = active_id`, then go to IDLE.
- **Dropping a request:** if `req[active_id]` falls after the grant, the operation still completes and `done` still pulses. There is no abort.
- **Changing `cycles`:** changes after the IDLE→LOAD sample are ignored.
- **Requests arriving during service:** they wait for IDLE. A requester whose `req` is still high in the IDLE cycle after its DONE is eligible again, but only after all other pending requesters (round-robin).

## Timing

- **Reset values:**
  - grant=0, done=0, timer_load=0, timer_cycles=0, active_id=0, ctl_busy=0, state=IDLE.
  - `last = NREQ-1`, so requester 0 has first priority.
- **Reset mid-operation:** the FSM is in IDLE on the next cycle. No `done` pulse is issued for the aborted requester. The timer is cleared by the same reset.
- **Non-zero count C, request sampled in IDLE at cycle n:**
  - n+1: LOAD with grant and `timer_load` high.
  - n+2 .. n+C+1: `timer_busy` high.
  - n+C+2: WAIT observes busy low.
  - n+C+3: DONE with `done` high.
  - n+C+4: IDLE.
  - Total service is C+4 cycles; the next grant comes no earlier than n+C+5.
- **Zero count:**
  - n+1: LOAD, with `timer_load` low.
  - n+2: DONE.
  - n+3: IDLE.
- **Pulse widths:** `timer_load` and `done` are each high for exactly one cycle per grant. `grant` is never multi-hot.

## Configuration

- **TIMER_ARB_FIXED_PRIORITY_EN defined:** IDLE selects the lowest asserted index regardless of `last`. A continuously requesting low index may starve higher indices.
- **Not defined (default):** round-robin from `last+1` as above. Every pending requester is serviced within NREQ grants.

## Test plan

NREQ=4, WIDTH=16 for all scenarios.

1. **Single request:** req=0010, cycles[1]=5, first IDLE at cycle 0 → grant=0010 and timer_load=1 with timer_cycles=5 at cycle 1; done=0010 at cycle 8; ctl_busy low at cycle 9.
2. **All four at once:** req=1111, all cycles=2 → grants to 0,1,2,3 in order starting at cycles 1, 7, 13, 19; four `done` pulses, each aligned to its grant.
3. **Zero count:** req=0100, cycles[2]=0 → grant at cycle 1, `timer_load` never asserted, done=0100 at cycle 2.
4. **Reset during WAIT:** req=0001, cycles=100, reset asserted at cycle 10 → at cycle 11 grant=0, ctl_busy=0, timer_busy=0, and no `done` pulse. A new req=1000 is then granted before requester 0.
5. **Fairness:** req[0] and req[3] held high, cycles=3 → grants alternate 0,3,0,3. With TIMER_ARB_FIXED_PRIORITY_EN, requester 0 is granted every time and requester 3 is never granted within 10 services.
